// File: rtl/uart_tx_word_sequencer.sv
// uart_tx_word_sequencer
// Queues byte/word transmit requests from the MMIO mapper and feeds them to
// the UART transmitter one byte at a time, LSB first. Each byte waits until
// the transmitter is idle, then waits for its completion pulse.
`timescale 1ns/1ps

module uart_tx_word_sequencer #(
  parameter int DEPTH   = 4,
  parameter int LEVEL_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_wr_en,
  input  logic [31:0]        in_wr_data,
  input  logic               in_wr_word,
  input  logic               in_clr_overflow,
  input  logic               in_tx_active,
  input  logic               in_tx_done,
  output logic               out_send_data_en,
  output logic [7:0]         out_data,
  output logic               out_full,
  output logic               out_empty,
  output logic [LEVEL_W-1:0] out_level,
  output logic               out_busy,
  output logic               out_overflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_e;

  // FIFO storage: each entry is {word_flag, data}
  logic [32:0]        mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [LEVEL_W-1:0] level_q;
  logic               overflow_q;

  // Sequencer state and datapath
  state_e             state_q, state_d;
  logic [31:0]        shift_q, shift_d;
  logic [2:0]         remain_q, remain_d;
  logic [7:0]         data_q, data_d;

  // Combinational controls
  logic               full_s;
  logic               empty_s;
  logic               push_s;
  logic               drop_s;
  logic               pop_s;
  logic               send_s;
  logic [32:0]        rd_entry_s;

  assign full_s     = (level_q == LEVEL_W'(DEPTH));
  assign empty_s    = (level_q == LEVEL_W'(0));
  // Full is judged on the registered level, so a write while full is dropped
  // even if the sequencer pops in the same cycle.
  assign push_s     = in_wr_en & ~full_s;
  assign drop_s     = in_wr_en & full_s;
  assign rd_entry_s = mem_q[rd_ptr_q];

  // FIFO storage write; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {in_wr_word, in_wr_data};
    end
  end

  // FIFO pointers and occupancy count; reset flushes all queued requests
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= PTR_W'(0);
      rd_ptr_q <= PTR_W'(0);
      level_q  <= LEVEL_W'(0);
    end else begin
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   level_q <= level_q + LEVEL_W'(1);
        2'b01:   level_q <= level_q - LEVEL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Sticky overflow flag; a dropped write outranks a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (drop_s) begin
      overflow_q <= 1'b1;
    end else if (in_clr_overflow) begin
      overflow_q <= 1'b0;
    end
  end

  // Sequencer state register and byte datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      shift_q  <= 32'd0;
      remain_q <= 3'd0;
      data_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      remain_q <= remain_d;
      data_q   <= data_d;
    end
  end

  // Next-state logic: pop in IDLE, strobe when transmitter idle, advance on done
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    remain_d = remain_q;
    data_d   = data_q;
    pop_s    = 1'b0;
    send_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s    = 1'b1;
          shift_d  = rd_entry_s[31:0];
          remain_d = rd_entry_s[32] ? 3'd4 : 3'd1;
          data_d   = rd_entry_s[7:0];
          state_d  = ST_SEND;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (!in_tx_active) begin
          send_s  = 1'b1;
          state_d = ST_WAIT_DONE;
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_WAIT_DONE: begin
        if (in_tx_done) begin
          shift_d  = {8'd0, shift_q[31:8]};
          remain_d = remain_q - 3'd1;
          if (remain_q != 3'd1) begin
            // Next byte is presented while in SEND; last byte stays visible in IDLE
            data_d  = shift_q[15:8];
            state_d = ST_SEND;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The strobe must appear in the very cycle the transmitter is seen idle
  assign out_send_data_en = send_s;
  assign out_data         = data_q;
  assign out_full         = full_s;
  assign out_empty        = empty_s;
  assign out_level        = level_q;
  assign out_busy         = (state_q != ST_IDLE);
  assign out_overflow     = overflow_q;

endmodule
